// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: funct codes, engine state, default width.
// ALU_DIV_EN selects whether div/divu are treated as multi-cycle operations.
package alu_pkg;

    localparam int ALU_WIDTH = 32;

    localparam logic [5:0] F_SLL   = 6'b000000;
    localparam logic [5:0] F_SRL   = 6'b000010;
    localparam logic [5:0] F_SRA   = 6'b000011;
    localparam logic [5:0] F_SLLV  = 6'b000100;
    localparam logic [5:0] F_SRLV  = 6'b000110;
    localparam logic [5:0] F_SRAV  = 6'b000111;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_XOR   = 6'b100110;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_SLTU  = 6'b101011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } alu_state_e;

    function automatic logic is_multi(input logic [5:0] f);
`ifdef ALU_DIV_EN
        return (f == F_MULT) || (f == F_MULTU) || (f == F_DIV) || (f == F_DIVU);
`else
        return (f == F_MULT) || (f == F_MULTU);
`endif
    endfunction

endpackage

// File: rtl/alu_muldiv.sv
// Iterative radix-2 multiply / restoring divide engine producing HI/LO.
// The divider state and datapath exist only when ALU_DIV_EN is defined.
module alu_muldiv
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             start_i,
`ifdef ALU_DIV_EN
    input  logic             is_div_i,
`endif
    input  logic             is_signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             out_free_i,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o,
    output alu_state_e       state_o
);
    localparam int SHW = $clog2(WIDTH);

    alu_state_e         state_q, state_d;
    logic [SHW-1:0]     cnt_q, cnt_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic               neg_q, neg_d;
    logic               rneg_q, rneg_d;
    logic               div_q, div_d;

    logic               sa, sb;
    logic [WIDTH-1:0]   ma, mb;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] prod;
`ifdef ALU_DIV_EN
    logic [WIDTH:0]     div_diff;
`endif

    assign state_o = state_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        b_d     = b_q;
        neg_d   = neg_q;
        rneg_d  = rneg_q;
        div_d   = div_q;
        done_o  = 1'b0;
        sa      = is_signed_i & a_i[WIDTH-1];
        sb      = is_signed_i & b_i[WIDTH-1];
        ma      = sa ? -a_i : a_i;
        mb      = sb ? -b_i : b_i;
        mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, b_q} : '0);
`ifdef ALU_DIV_EN
        div_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, b_q};
`endif
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    div_d = 1'b0;
`ifdef ALU_DIV_EN
                    div_d = is_div_i;
`endif
                    acc_d   = {{WIDTH{1'b0}}, ma};
                    b_d     = mb;
                    cnt_d   = SHW'(WIDTH - 1);
                    // A zero divisor keeps the unsigned quotient of all ones.
                    neg_d   = (sa ^ sb) & ~(div_d & (b_i == '0));
                    rneg_d  = sa;
                    state_d = div_d ? ST_DIV : ST_MUL;
                end
            end
            ST_MUL: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                if (cnt_q == '0) state_d = ST_FIX;
                else             cnt_d   = cnt_q - SHW'(1);
            end
`ifdef ALU_DIV_EN
            ST_DIV: begin
                if (!div_diff[WIDTH]) acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
                else                  acc_d = {acc_q[2*WIDTH-2:0], 1'b0};
                if (cnt_q == '0) state_d = ST_FIX;
                else             cnt_d   = cnt_q - SHW'(1);
            end
`endif
            ST_FIX: begin
                done_o = out_free_i;
                if (out_free_i) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sign correction is applied on the way out so the FIX cycle just publishes.
    always_comb begin
        prod = neg_q ? -acc_q : acc_q;
        hi_o = prod[2*WIDTH-1:WIDTH];
        lo_o = prod[WIDTH-1:0];
        if (div_q) begin
            hi_o = rneg_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
            lo_o = neg_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            acc_q   <= '0;
            b_q     <= '0;
            neg_q   <= 1'b0;
            rneg_q  <= 1'b0;
            div_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
            b_q     <= b_d;
            neg_q   <= neg_d;
            rneg_q  <= rneg_d;
            div_q   <= div_d;
        end
    end

endmodule

// File: rtl/alu_seq.sv
// Sequential MIPS R-type ALU: single-cycle datapath, output register, HI/LO.
// Define ALU_DIV_EN to include div/divu; otherwise they report err.
module alu_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [5:0]               funct,
    input  logic [$clog2(WIDTH)-1:0] shamt,
    input  logic [WIDTH-1:0]         rs,
    input  logic [WIDTH-1:0]         rt,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         rd,
    output logic                     zflag,
    output logic                     err,
    output logic [WIDTH-1:0]         hi,
    output logic [WIDTH-1:0]         lo,
    output alu_state_e               dbg_state
);
    localparam int SHW = $clog2(WIDTH);

    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] rd_q, rd_d;
    logic             zflag_q, zflag_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             zpend_q, zpend_d;

    logic             out_free, accept, multi, bad, md_done;
    logic [WIDTH-1:0] res, md_hi, md_lo;

    // Handshake: an op is taken on a rising edge with in_valid && in_ready; a
    // result is taken with out_valid && out_ready and is held stable until then.
    assign out_free = !out_valid_q || out_ready;
    assign in_ready = rstn && (dbg_state == ST_IDLE) && out_free;
    assign accept   = in_valid && in_ready;
    assign multi    = is_multi(funct);

    alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk         (clk),
        .rstn        (rstn),
        .start_i     (accept && multi),
`ifdef ALU_DIV_EN
        .is_div_i    (funct[1]),
`endif
        .is_signed_i (!funct[0]),
        .a_i         (rs),
        .b_i         (rt),
        .out_free_i  (out_free),
        .done_o      (md_done),
        .hi_o        (md_hi),
        .lo_o        (md_lo),
        .state_o     (dbg_state)
    );

    always_comb begin
        res = '0;
        bad = 1'b0;
        case (funct)
            F_ADD:          res = rs + rt;
            F_SUB:          res = rs - rt;
            F_AND:          res = rs & rt;
            F_OR:           res = rs | rt;
            F_XOR:          res = rs ^ rt;
            F_NOR:          res = ~(rs | rt);
            F_SLT:          res = {{(WIDTH-1){1'b0}}, ($signed(rs) < $signed(rt))};
            F_SLTU:         res = {{(WIDTH-1){1'b0}}, (rs < rt)};
            F_SLL:          res = rt << shamt;
            F_SRL:          res = rt >> shamt;
            F_SRA:          res = $signed(rt) >>> shamt;
            F_SLLV:         res = rt << rs[SHW-1:0];
            F_SRLV:         res = rt >> rs[SHW-1:0];
            F_SRAV:         res = $signed(rt) >>> rs[SHW-1:0];
            F_MFHI:         res = hi_q;
            F_MFLO:         res = lo_q;
            F_MTHI, F_MTLO: res = rs;
            default:        bad = 1'b1;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        rd_d        = rd_q;
        zflag_d     = zflag_q;
        err_d       = err_q;
        hi_d        = hi_q;
        lo_d        = lo_q;
        zpend_d     = zpend_q;
        if (md_done) begin
            out_valid_d = 1'b1;
            rd_d        = md_lo;
            zflag_d     = zpend_q;
            err_d       = 1'b0;
            hi_d        = md_hi;
            lo_d        = md_lo;
        end else if (accept && !multi) begin
            out_valid_d = 1'b1;
            rd_d        = res;
            zflag_d     = (rs == rt);
            err_d       = bad;
            if (funct == F_MTHI) hi_d = rs;
            if (funct == F_MTLO) lo_d = rs;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
            rd_d        = '0;
            zflag_d     = 1'b0;
            err_d       = 1'b0;
        end
        if (accept && multi) zpend_d = (rs == rt);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid_q <= 1'b0;
            rd_q        <= '0;
            zflag_q     <= 1'b0;
            err_q       <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
            zpend_q     <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            rd_q        <= rd_d;
            zflag_q     <= zflag_d;
            err_q       <= err_d;
            hi_q        <= hi_d;
            lo_q        <= lo_d;
            zpend_q     <= zpend_d;
        end
    end

    assign out_valid = out_valid_q;
    assign rd        = rd_q;
    assign zflag     = zflag_q;
    assign err       = err_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH = 32; div checks follow ALU_DIV_EN.
module tb_alu_seq;
    import alu_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [5:0]   funct = '0;
    logic [4:0]   shamt = '0;
    logic [W-1:0] rs = '0;
    logic [W-1:0] rt = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] rd;
    logic         zflag;
    logic         err;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    alu_state_e   dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    alu_seq #(.WIDTH(W)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct     (funct),
        .shamt     (shamt),
        .rs        (rs),
        .rt        (rt),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rd        (rd),
        .zflag     (zflag),
        .err       (err),
        .hi        (hi),
        .lo        (lo),
        .dbg_state (dbg_state)
    );

    // Present one op, wait (bounded) for in_ready, return #1 after the accepting edge.
    task automatic send(input logic [5:0] f, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [4:0] sh);
        int t;
        t = 0;
        while (!in_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL send_ready: in_ready=%0b required 1 (funct=%b)", in_ready, f);
        end
        funct = f; rs = a; rt = b; shamt = sh; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Edges until out_valid, capped at 200.
    task automatic wait_done(output int cyc);
        cyc = 0;
        while (!out_valid && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_cmp++;
        if ({in_ready, out_valid, zflag, err, rd, hi, lo} !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: in_ready=%0b out_valid=%0b zflag=%0b err=%0b rd=%h hi=%h lo=%h required all 0",
                     in_ready, out_valid, zflag, err, rd, hi, lo);
        end
        n_cmp++;
        if (dbg_state !== ST_IDLE) begin
            n_bad++;
            $display("FAIL reset_state: got %0d required %0d", dbg_state, ST_IDLE);
        end
        rstn = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_release_ready: got %0b required 1", in_ready);
        end
    endtask

    task automatic test_add();
        send(F_ADD, 32'd7, 32'd5, 5'd0);
        n_cmp++;
        if ({out_valid, rd, zflag, err} !== {1'b1, 32'd12, 1'b0, 1'b0}) begin
            n_bad++;
            $display("FAIL add_result: out_valid=%0b rd=%h zflag=%0b err=%0b required 1/0000000c/0/0",
                     out_valid, rd, zflag, err);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL add_handoff: out_valid=%0b required 0", out_valid);
        end
    endtask

    task automatic test_single();
        logic [5:0]   tf [9] = '{F_SRAV, F_SLTU, F_SLT, F_SLL, F_SRL, F_NOR, F_SUB, F_XOR, 6'b111111};
        logic [W-1:0] ta [9] = '{32'd4, 32'd1, 32'd1, 32'd0, 32'd0, 32'h0F0F0F0F, 32'd3, 32'h12345678, 32'd1};
        logic [W-1:0] tb [9] = '{32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'hF0000000,
                                 32'h00FF00FF, 32'd5, 32'hFFFFFFFF, 32'd2};
        logic [4:0]   ts [9] = '{5'd0, 5'd0, 5'd0, 5'd4, 5'd28, 5'd0, 5'd0, 5'd0, 5'd0};
        logic [W-1:0] te [9] = '{32'hF8000000, 32'd1, 32'd0, 32'h10, 32'hF, 32'hF000F000,
                                 32'hFFFFFFFE, 32'hEDCBA987, 32'd0};
        logic         tr [9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 9; i++) begin
            send(tf[i], ta[i], tb[i], ts[i]);
            n_cmp++;
            if (rd !== te[i] || out_valid !== 1'b1) begin
                n_bad++;
                $display("FAIL single_rd[%0d]: rd=%h out_valid=%0b required %h/1", i, rd, out_valid, te[i]);
            end
            n_cmp++;
            if (err !== tr[i]) begin
                n_bad++;
                $display("FAIL single_err[%0d]: err=%0b required %0b", i, err, tr[i]);
            end
        end
        send(F_SUB, 32'd5, 32'd5, 5'd0);
        n_cmp++;
        if ({rd, zflag} !== {32'd0, 1'b1}) begin
            n_bad++;
            $display("FAIL sub_zflag: rd=%h zflag=%0b required 00000000/1", rd, zflag);
        end
    endtask

    task automatic test_hilo();
        send(F_MTHI, 32'h0000AAAA, 32'd0, 5'd0);
        n_cmp++;
        if ({rd, hi} !== {32'h0000AAAA, 32'h0000AAAA}) begin
            n_bad++;
            $display("FAIL mthi: rd=%h hi=%h required 0000aaaa/0000aaaa", rd, hi);
        end
        send(F_MTLO, 32'h00005555, 32'd0, 5'd0);
        n_cmp++;
        if (lo !== 32'h00005555) begin
            n_bad++;
            $display("FAIL mtlo: lo=%h required 00005555", lo);
        end
        send(F_MFHI, 32'd0, 32'd0, 5'd0);
        n_cmp++;
        if (rd !== 32'h0000AAAA) begin
            n_bad++;
            $display("FAIL mfhi: rd=%h required 0000aaaa", rd);
        end
        send(F_MFLO, 32'd0, 32'd0, 5'd0);
        n_cmp++;
        if (rd !== 32'h00005555) begin
            n_bad++;
            $display("FAIL mflo: rd=%h required 00005555", rd);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        funct = F_ADD; rs = 32'd1; rt = 32'd2; in_valid = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if ({out_valid, rd, in_ready} !== {1'b1, 32'd3, 1'b1}) begin
            n_bad++;
            $display("FAIL b2b_0: out_valid=%0b rd=%h in_ready=%0b required 1/00000003/1", out_valid, rd, in_ready);
        end
        rs = 32'd10; rt = 32'd20;
        @(posedge clk); #1;
        n_cmp++;
        if ({out_valid, rd, in_ready} !== {1'b1, 32'd30, 1'b1}) begin
            n_bad++;
            $display("FAIL b2b_1: out_valid=%0b rd=%h in_ready=%0b required 1/0000001e/1", out_valid, rd, in_ready);
        end
        funct = F_AND; rs = 32'hFF; rt = 32'h0F;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++;
        if ({out_valid, rd} !== {1'b1, 32'h0F}) begin
            n_bad++;
            $display("FAIL b2b_2: out_valid=%0b rd=%h required 1/0000000f", out_valid, rd);
        end
    endtask

    task automatic test_mult();
        int  lat;
        logic busy_ok;
        send(F_MULT, 32'hFFFFFFFE, 32'd3, 5'd0);
        lat = 0;
        busy_ok = 1'b1;
        while (!out_valid && lat < 100) begin
            if (in_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        n_cmp++;
        if (lat != 33) begin
            n_bad++;
            $display("FAIL mult_latency: got %0d edges required 33", lat);
        end
        n_cmp++;
        if (busy_ok !== 1'b1) begin
            n_bad++;
            $display("FAIL mult_in_ready_busy: in_ready rose during mult, required low throughout");
        end
        n_cmp++;
        if ({hi, lo, rd} !== {32'hFFFFFFFF, 32'hFFFFFFFA, 32'hFFFFFFFA}) begin
            n_bad++;
            $display("FAIL mult_result: hi=%h lo=%h rd=%h required ffffffff/fffffffa/fffffffa", hi, lo, rd);
        end
        send(F_MFHI, 32'd0, 32'd0, 5'd0);
        n_cmp++;
        if (rd !== 32'hFFFFFFFF) begin
            n_bad++;
            $display("FAIL mfhi_after_mult: rd=%h required ffffffff", rd);
        end
        send(F_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0);
        wait_done(lat);
        n_cmp++;
        if ({hi, lo, zflag} !== {32'hFFFFFFFE, 32'h00000001, 1'b1}) begin
            n_bad++;
            $display("FAIL multu_result: hi=%h lo=%h zflag=%0b required fffffffe/00000001/1", hi, lo, zflag);
        end
        send(F_MULT, 32'hFFFFFFFD, 32'hFFFFFFFB, 5'd0);
        wait_done(lat);
        n_cmp++;
        if ({hi, lo, lat} !== {32'h0, 32'hF, 33}) begin
            n_bad++;
            $display("FAIL mult_negneg: hi=%h lo=%h lat=%0d required 00000000/0000000f/33", hi, lo, lat);
        end
    endtask

    task automatic test_div();
        int lat;
`ifdef ALU_DIV_EN
        send(F_DIV, 32'hFFFFFFF9, 32'd2, 5'd0);
        wait_done(lat);
        n_cmp++;
        if ({lo, hi, rd, lat} !== {32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFFD, 33}) begin
            n_bad++;
            $display("FAIL div_neg7_2: lo=%h hi=%h rd=%h lat=%0d required fffffffd/ffffffff/fffffffd/33", lo, hi, rd, lat);
        end
        send(F_DIVU, 32'd9, 32'd0, 5'd0);
        wait_done(lat);
        n_cmp++;
        if ({lo, hi} !== {32'hFFFFFFFF, 32'd9}) begin
            n_bad++;
            $display("FAIL divu_by_zero: lo=%h hi=%h required ffffffff/00000009", lo, hi);
        end
        send(F_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd0);
        wait_done(lat);
        n_cmp++;
        if ({lo, hi} !== {32'h80000000, 32'd0}) begin
            n_bad++;
            $display("FAIL div_min_neg1: lo=%h hi=%h required 80000000/00000000", lo, hi);
        end
`else
        send(F_MTHI, 32'h1111, 32'd0, 5'd0);
        send(F_MTLO, 32'h2222, 32'd0, 5'd0);
        send(F_DIV, 32'hFFFFFFF9, 32'd2, 5'd0);
        lat = 0;
        n_cmp++;
        if ({out_valid, err, rd} !== {1'b1, 1'b1, 32'd0}) begin
            n_bad++;
            $display("FAIL div_disabled: out_valid=%0b err=%0b rd=%h required 1/1/00000000", out_valid, err, rd);
        end
        n_cmp++;
        if ({hi, lo, dbg_state} !== {32'h1111, 32'h2222, ST_IDLE}) begin
            n_bad++;
            $display("FAIL div_disabled_hilo: hi=%h lo=%h state=%0d required 00001111/00002222/0", hi, lo, dbg_state);
        end
`endif
    endtask

    task automatic test_stall();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(F_ADD, 32'd2, 32'd3, 5'd0);
        funct = F_SUB; rs = 32'd9; rt = 32'd2; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({out_valid, rd, in_ready} !== {1'b1, 32'd5, 1'b0}) begin
                n_bad++;
                $display("FAIL stall_hold[%0d]: out_valid=%0b rd=%h in_ready=%0b required 1/00000005/0",
                         i, out_valid, rd, in_ready);
            end
        end
        out_ready = 1'b1;
        #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_release_ready: in_ready=%0b required 1", in_ready);
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_cmp++;
        if ({out_valid, rd} !== {1'b1, 32'd7}) begin
            n_bad++;
            $display("FAIL stall_next_op: out_valid=%0b rd=%h required 1/00000007", out_valid, rd);
        end
    endtask

    task automatic test_reset_mid();
        send(F_MTHI, 32'hDEAD, 32'd0, 5'd0);
        send(F_MULTU, 32'h12345678, 32'd9, 5'd0);
        repeat (9) @(posedge clk);
        #1;
        n_cmp++;
        if (dbg_state !== ST_MUL) begin
            n_bad++;
            $display("FAIL midop_busy: state=%0d required %0d", dbg_state, ST_MUL);
        end
        rstn = 1'b0;
        #1;
        n_cmp++;
        if ({in_ready, out_valid, zflag, err, rd, hi, lo, dbg_state} !== '0) begin
            n_bad++;
            $display("FAIL midop_reset: in_ready=%0b out_valid=%0b rd=%h hi=%h lo=%h state=%0d required all 0",
                     in_ready, out_valid, rd, hi, lo, dbg_state);
        end
        #3;
        rstn = 1'b1;
        @(posedge clk); #1;
        send(F_MFLO, 32'd0, 32'd0, 5'd0);
        n_cmp++;
        if ({out_valid, rd, hi} !== {1'b1, 32'd0, 32'd0}) begin
            n_bad++;
            $display("FAIL midop_mflo: out_valid=%0b rd=%h hi=%h required 1/00000000/00000000", out_valid, rd, hi);
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_single();
        test_hilo();
        test_back_to_back();
        test_mult();
        test_div();
        test_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
